res_readout_ctrl: RTL and testbench

Sequences host readout of the Winograd multiplier's result matrix. On each `calc_done` pulse it captures the flat `N*N*BITS` result into a shadow buffer and serves it as registered, word-wide reads in a byte-addressed window. It tracks which words the host has read, and frees the buffer for the next result once every word has been read at least once. It sits between the multiplier core and the host read bus, and stalls the multiplier through `buf_free`.

---
 rtl/res_readout_ctrl_if.sv | 33 +++
 rtl/res_readout_ctrl.sv | 144 ++++++++++++++
 tb/tb_res_readout_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/res_readout_ctrl_if.sv
// Bus bundle between the result-readout controller and its host/multiplier side.
// The master drives capture and read requests; the slave returns read data and status.
interface res_readout_ctrl_if #(
  parameter int unsigned BITS       = 8,
  parameter int unsigned N          = 8,
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned ADDR_WIDTH = 10
);
  localparam int unsigned WW    = WIDTH * BITS;
  localparam int unsigned ALL_W = N * N * BITS;

  logic                  calc_done;
  logic [ALL_W-1:0]      all;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  clr;
  logic [WW-1:0]         rd_data;
  logic                  rd_valid;
  logic                  hit;
  logic                  res_ready;
  logic                  buf_free;
  logic                  overrun;

  modport master (
    output calc_done, all, rd_en, addr, clr,
    input  rd_data, rd_valid, hit, res_ready, buf_free, overrun
  );

  modport slave (
    input  calc_done, all, rd_en, addr, clr,
    output rd_data, rd_valid, hit, res_ready, buf_free, overrun
  );
endinterface

// File: rtl/res_readout_ctrl.sv
// Captures the multiplier result into a shadow buffer and serves it as word reads in a
// byte-addressed window; the buffer is released once every word has been read at least once.
module res_readout_ctrl #(
  parameter int unsigned BITS       = 8,
  parameter int unsigned N          = 8,
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned OFFSET     = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  res_readout_ctrl_if.slave   bus
);
  localparam int unsigned WW   = WIDTH * BITS;
  localparam int unsigned WB   = WW / 8;
  localparam int unsigned NW   = N * N / WIDTH;
  localparam int unsigned WIN  = N * N * BITS / 8;
  localparam int unsigned WBL  = $clog2(WB);
  localparam int unsigned IDXW = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned AXW  = ADDR_WIDTH + 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [NW-1:0]         seen_q, seen_d;
  logic                  overrun_q, overrun_d;
  logic                  res_ready_q, res_ready_d;
  logic                  buf_free_q, buf_free_d;
  logic                  cap_c;

  logic [WW-1:0]         shadow_q [NW];
  logic [WW-1:0]         rd_data_q;
  logic                  rd_valid_q;
  logic                  hit_q;

  logic [ADDR_WIDTH:0]   off_c;
  logic                  in_win_c;
  logic [IDXW-1:0]       idx_c;
  logic [NW-1:0]         hit_mask_c;
  logic [NW-1:0]         seen_rd_c;

  // Window decode: the extra MSB of the offset is the borrow, so addresses below the base never alias in.
  always_comb begin
    off_c      = {1'b0, bus.addr} - AXW'(OFFSET);
    in_win_c   = !off_c[ADDR_WIDTH] && (32'(off_c[ADDR_WIDTH-1:0]) < WIN);
    idx_c      = IDXW'(off_c[ADDR_WIDTH-1:0] >> WBL);
    hit_mask_c = (bus.rd_en && in_win_c) ? (NW'(1) << idx_c) : '0;
    seen_rd_c  = seen_q | hit_mask_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      seen_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      seen_q    <= seen_d;
      overrun_q <= overrun_d;
    end
  end

  // Next state: clr dominates; a final read coinciding with calc_done hands straight over to the new result.
  always_comb begin
    state_d   = state_q;
    seen_d    = seen_q;
    overrun_d = overrun_q;
    cap_c     = 1'b0;
    if (bus.clr) begin
      state_d   = EMPTY;
      seen_d    = '0;
      overrun_d = 1'b0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (bus.calc_done) begin
            cap_c   = 1'b1;
            seen_d  = '0;
            state_d = FULL;
          end
        end
        FULL: begin
          seen_d = seen_rd_c;
          if (&seen_rd_c) begin
            if (bus.calc_done) begin
              cap_c  = 1'b1;
              seen_d = '0;
            end else begin
              state_d = EMPTY;
            end
          end else if (bus.calc_done) begin
            overrun_d = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    res_ready_d = (state_d == FULL);
    buf_free_d  = (state_d == EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_ready_q <= 1'b0;
      buf_free_q  <= 1'b1;
    end else begin
      res_ready_q <= res_ready_d;
      buf_free_q  <= buf_free_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NW; k++) shadow_q[k] <= '0;
    end else if (cap_c) begin
      for (int unsigned k = 0; k < NW; k++) shadow_q[k] <= bus.all[k*WW +: WW];
    end
  end

  // Read port: data and hit hold between strobes, valid pulses once per strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_data_q <= in_win_c ? shadow_q[idx_c] : '0;
        hit_q     <= in_win_c;
      end
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.hit       = hit_q;
  assign bus.res_ready = res_ready_q;
  assign bus.buf_free  = buf_free_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_res_readout_ctrl.sv
// Directed bench for res_readout_ctrl with the window placed at 0x40 (16 words of 4 bytes).
module tb_res_readout_ctrl;
  localparam int unsigned BITS       = 8;
  localparam int unsigned N          = 8;
  localparam int unsigned WIDTH      = 4;
  localparam int unsigned ADDR_WIDTH = 10;
  localparam int unsigned OFFSET     = 32'h40;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  res_readout_ctrl_if #(.BITS(BITS), .N(N), .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  res_readout_ctrl #(
    .BITS(BITS), .N(N), .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .OFFSET(OFFSET)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_all(input logic [31:0] base);
    for (int k = 0; k < 16; k++) bus.all[k*32 +: 32] = base + 32'(k);
  endtask

  task automatic rd(input logic [9:0] a);
    bus.addr  = a;
    bus.rd_en = 1'b1;
    cyc();
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.calc_done = 1'b0; bus.all = '0; bus.rd_en = 1'b0; bus.addr = '0; bus.clr = 1'b0;
    #12;
    vectors++;
    if ({bus.rd_valid, bus.hit, bus.res_ready, bus.buf_free, bus.overrun, bus.rd_data} !== {5'b00010, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b/%h want 00010/00000000",
               {bus.rd_valid, bus.hit, bus.res_ready, bus.buf_free, bus.overrun}, bus.rd_data);
    end
    @(negedge clk) rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_capture();
    load_all(32'hA0A0_0000);
    bus.calc_done = 1'b1; cyc(); bus.calc_done = 1'b0;
    vectors++;
    if ({bus.res_ready, bus.buf_free} !== 2'b10) begin
      miscompares++; $display("FAIL cap_ready: got %b want 10", {bus.res_ready, bus.buf_free});
    end
    bus.rd_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus.addr = 10'(32'h40 + 32'(4*k));
      cyc();
      vectors++;
      if ({bus.rd_valid, bus.hit, bus.rd_data} !== {2'b11, 32'hA0A0_0000 + 32'(k)}) begin
        miscompares++;
        $display("FAIL cap_rd%0d: got %b/%h want 11/%h", k, {bus.rd_valid, bus.hit}, bus.rd_data,
                 32'hA0A0_0000 + 32'(k));
      end
    end
    bus.rd_en = 1'b0;
    vectors++;
    if ({bus.res_ready, bus.buf_free} !== 2'b01) begin
      miscompares++; $display("FAIL cap_freed: got %b want 01", {bus.res_ready, bus.buf_free});
    end
    cyc();
    vectors++;
    if ({bus.rd_valid, bus.hit, bus.rd_data} !== {2'b01, 32'hA0A0_000F}) begin
      miscompares++;
      $display("FAIL rd_hold: got %b/%h want 01/a0a0000f", {bus.rd_valid, bus.hit}, bus.rd_data);
    end
  endtask

  task automatic test_window_edges();
    logic [9:0]  addrs [4] = '{10'h3F, 10'h80, 10'h7F, 10'h41};
    logic [33:0] exps  [4] = '{{2'b10, 32'h0}, {2'b10, 32'h0},
                               {2'b11, 32'hA0A0_000F}, {2'b11, 32'hA0A0_0000}};
    for (int i = 0; i < 4; i++) begin
      rd(addrs[i]);
      vectors++;
      if ({bus.rd_valid, bus.hit, bus.rd_data} !== exps[i]) begin
        miscompares++;
        $display("FAIL win_%h: got %h want %h", addrs[i], {bus.rd_valid, bus.hit, bus.rd_data}, exps[i]);
      end
    end
    vectors++;
    if (bus.buf_free !== 1'b1) begin
      miscompares++; $display("FAIL win_empty_state: got buf_free=%b want 1", bus.buf_free);
    end
  endtask

  task automatic test_incomplete();
    load_all(32'hB0B0_0000);
    bus.calc_done = 1'b1; cyc(); bus.calc_done = 1'b0;
    bus.rd_en = 1'b1;
    for (int k = 0; k < 15; k++) begin
      bus.addr = 10'(32'h40 + 32'(4*k));
      cyc();
      vectors++;
      if (bus.rd_data !== 32'hB0B0_0000 + 32'(k)) begin
        miscompares++;
        $display("FAIL inc_rd%0d: got %h want %h", k, bus.rd_data, 32'hB0B0_0000 + 32'(k));
      end
    end
    bus.rd_en = 1'b0;
    load_all(32'hC0C0_0000);
    bus.calc_done = 1'b1; cyc(); bus.calc_done = 1'b0;
    vectors++;
    if ({bus.overrun, bus.res_ready, bus.buf_free} !== 3'b110) begin
      miscompares++;
      $display("FAIL inc_overrun: got %b want 110", {bus.overrun, bus.res_ready, bus.buf_free});
    end
    rd(10'h4C);
    vectors++;
    if ({bus.res_ready, bus.rd_data} !== {1'b1, 32'hB0B0_0003}) begin
      miscompares++;
      $display("FAIL inc_kept: got %b/%h want 1/b0b00003", bus.res_ready, bus.rd_data);
    end
    rd(10'h7C);
    vectors++;
    if ({bus.overrun, bus.res_ready, bus.buf_free, bus.rd_data} !== {3'b101, 32'hB0B0_000F}) begin
      miscompares++;
      $display("FAIL inc_free: got %b/%h want 101/b0b0000f",
               {bus.overrun, bus.res_ready, bus.buf_free}, bus.rd_data);
    end
  endtask

  task automatic test_back_to_back();
    bus.clr = 1'b1; cyc(); bus.clr = 1'b0;
    vectors++;
    if ({bus.overrun, bus.buf_free} !== 2'b01) begin
      miscompares++; $display("FAIL b2b_clr: got %b want 01", {bus.overrun, bus.buf_free});
    end
    load_all(32'hD0D0_0000);
    bus.calc_done = 1'b1; cyc(); bus.calc_done = 1'b0;
    bus.rd_en = 1'b1;
    for (int k = 0; k < 15; k++) begin
      bus.addr = 10'(32'h40 + 32'(4*k));
      cyc();
    end
    vectors++;
    if (bus.rd_data !== 32'hD0D0_000E) begin
      miscompares++; $display("FAIL b2b_rd14: got %h want d0d0000e", bus.rd_data);
    end
    load_all(32'hE0E0_0000);
    bus.all[15*32 +: 32] = 32'h5555_5555;
    bus.addr = 10'h7C; bus.calc_done = 1'b1;
    cyc();
    bus.rd_en = 1'b0; bus.calc_done = 1'b0;
    vectors++;
    if ({bus.rd_valid, bus.hit, bus.rd_data} !== {2'b11, 32'hD0D0_000F}) begin
      miscompares++;
      $display("FAIL b2b_old_word: got %b/%h want 11/d0d0000f", {bus.rd_valid, bus.hit}, bus.rd_data);
    end
    vectors++;
    if ({bus.overrun, bus.res_ready, bus.buf_free} !== 3'b010) begin
      miscompares++;
      $display("FAIL b2b_state: got %b want 010", {bus.overrun, bus.res_ready, bus.buf_free});
    end
    rd(10'h7C);
    vectors++;
    if (bus.rd_data !== 32'h5555_5555) begin
      miscompares++; $display("FAIL b2b_new_w15: got %h want 55555555", bus.rd_data);
    end
    rd(10'h40);
    vectors++;
    if ({bus.res_ready, bus.rd_data} !== {1'b1, 32'hE0E0_0000}) begin
      miscompares++; $display("FAIL b2b_new_w0: got %b/%h want 1/e0e00000", bus.res_ready, bus.rd_data);
    end
  endtask

  task automatic test_clr_reset();
    load_all(32'hF0F0_0000);
    bus.calc_done = 1'b1; cyc(); bus.calc_done = 1'b0;
    vectors++;
    if (bus.overrun !== 1'b1) begin
      miscompares++; $display("FAIL clr_pre_overrun: got %b want 1", bus.overrun);
    end
    bus.rd_en = 1'b1;
    for (int k = 1; k < 6; k++) begin
      bus.addr = 10'(32'h40 + 32'(4*k));
      cyc();
      vectors++;
      if (bus.rd_data !== 32'hE0E0_0000 + 32'(k)) begin
        miscompares++;
        $display("FAIL clr_rd%0d: got %h want %h", k, bus.rd_data, 32'hE0E0_0000 + 32'(k));
      end
    end
    bus.rd_en = 1'b0;
    load_all(32'h1234_0000);
    bus.clr = 1'b1; bus.calc_done = 1'b1; cyc(); bus.clr = 1'b0; bus.calc_done = 1'b0;
    vectors++;
    if ({bus.overrun, bus.res_ready, bus.buf_free} !== 3'b001) begin
      miscompares++;
      $display("FAIL clr_state: got %b want 001", {bus.overrun, bus.res_ready, bus.buf_free});
    end
    rd(10'h44);
    vectors++;
    if (bus.rd_data !== 32'hE0E0_0001) begin
      miscompares++; $display("FAIL clr_no_capture: got %h want e0e00001", bus.rd_data);
    end
    bus.calc_done = 1'b1; cyc(); bus.calc_done = 1'b0;
    rd(10'h48);
    vectors++;
    if ({bus.rd_valid, bus.res_ready, bus.rd_data} !== {2'b11, 32'h1234_0002}) begin
      miscompares++;
      $display("FAIL pre_rst_rd: got %b/%h want 11/12340002", {bus.rd_valid, bus.res_ready}, bus.rd_data);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.rd_valid, bus.hit, bus.res_ready, bus.buf_free, bus.overrun, bus.rd_data} !== {5'b00010, 32'h0}) begin
      miscompares++;
      $display("FAIL async_rst: got %b/%h want 00010/00000000",
               {bus.rd_valid, bus.hit, bus.res_ready, bus.buf_free, bus.overrun}, bus.rd_data);
    end
    @(negedge clk) rst_n = 1'b1;
    rd(10'h40);
    vectors++;
    if ({bus.rd_valid, bus.hit, bus.buf_free, bus.rd_data} !== {3'b111, 32'h0}) begin
      miscompares++;
      $display("FAIL rst_shadow: got %b/%h want 111/00000000", {bus.rd_valid, bus.hit, bus.buf_free}, bus.rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_window_edges();
    test_incomplete();
    test_back_to_back();
    test_clr_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
